// File: rtl/bcd_counter_mux.sv
// Multi-digit BCD up/down counter with prescaler, load/clear, wrap flags and a
// time-multiplexed 7-segment driver that scans one digit at a time.
module bcd_counter_mux #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1,
  parameter int SCAN_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  carry,
  output logic                  borrow,
  output logic                  load_err,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_sel
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0] presc;
  logic          tick;

  logic [DIGITS:0]          inc_c;
  logic [DIGITS:0]          dec_b;
  logic [4*DIGITS-1:0]      inc_val;
  logic [4*DIGITS-1:0]      dec_val;
  logic [4*DIGITS-1:0]      load_fix;
  logic [DIGITS-1:0]        nib_bad;
  logic [3:0]               nib_at [DIGITS];

  logic [SW-1:0] scan_cnt;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_next;
  logic          scan_wrap;

  assign tick = en && (presc == PW'(PRESCALE - 1));

  assign inc_c[0] = 1'b1;
  assign dec_b[0] = 1'b1;

  // Ripple chains: the carry/borrow out of the top digit is the wrap flag.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] d;
      logic [3:0] lv;
      assign d  = bcd[4*gi +: 4];
      assign lv = load_val[4*gi +: 4];

      assign inc_val[4*gi +: 4] = !inc_c[gi] ? d : ((d == 4'd9) ? 4'd0 : d + 4'd1);
      assign inc_c[gi+1]        = inc_c[gi] && (d == 4'd9);

      assign dec_val[4*gi +: 4] = !dec_b[gi] ? d : ((d == 4'd0) ? 4'd9 : d - 4'd1);
      assign dec_b[gi+1]        = dec_b[gi] && (d == 4'd0);

      assign nib_bad[gi]         = (lv > 4'd9);
      assign load_fix[4*gi +: 4] = nib_bad[gi] ? 4'd0 : lv;

      assign nib_at[gi] = d;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd      <= '0;
      presc    <= '0;
      carry    <= 1'b0;
      borrow   <= 1'b0;
      load_err <= 1'b0;
    end else begin
      carry    <= 1'b0;
      borrow   <= 1'b0;
      load_err <= 1'b0;
      if (clear) begin
        bcd   <= '0;
        presc <= '0;
      end else if (load) begin
        bcd      <= load_fix;
        presc    <= '0;
        load_err <= |nib_bad;
      end else begin
        if (en) presc <= tick ? '0 : presc + 1'b1;
        if (tick) begin
          if (up) begin
            bcd   <= inc_val;
            carry <= inc_c[DIGITS];
          end else begin
            bcd    <= dec_val;
            borrow <= dec_b[DIGITS];
          end
        end
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  assign scan_wrap = (scan_cnt == SW'(SCAN_DIV - 1));

  always_comb begin
    idx_next = idx;
    if (scan_wrap) idx_next = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
  end

  // seg and dig_sel are loaded together from the next index so they never disagree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      dig_sel  <= DIGITS'(1);
      seg      <= 7'h3F;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      idx      <= idx_next;
      dig_sel  <= DIGITS'(1) << idx_next;
      seg      <= seg7(nib_at[idx_next]);
    end
  end

endmodule
